seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Parametrised sequential shift-add multiplier for the ALU datapath. It is the
//   clocked successor to the 3x4 array multiplier: operand widths are parameters,
//   operands enter through a valid/ready handshake, and one multiplier bit is
//   retired per clock. The product is held until the consumer accepts it.
//   Sits between the ALU operand registers and the result mux; only one operation
//   is in flight at a time.
// PARAMETERS
//   WA  3  multiplier (A) width, >=2; equals the iteration count
//   WB  4  multiplicand (B) width, >=2
//   WP  WA+WB  product width (localparam, not overridable)
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands a_in/b_in valid
//   in_ready   out  1   block can accept operands (high only in IDLE)
//   a_in       in   WA  multiplier
//   b_in       in   WB  multiplicand
//   out_valid  out  1   product valid (high only in DONE)
//   out_ready  in   1   consumer accepts product
//   p_out      out  WP  product, registered
//   busy       out  1   high in RUN or DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; in_ready=1 after release; out_valid=0,
//     busy=0, p_out=0, internal acc/count/operand regs=0.
//   FSM IDLE->RUN on in_valid&in_ready; latches a_in, b_in; acc=0; cnt=0.
//   RUN: each cycle, if A[cnt]=1, acc[WP:cnt] += B (WB+1-bit add, carry kept);
//     cnt++. After cnt==WA-1 is processed, ->DONE. Exactly WA RUN cycles.
//   Latency: operands accepted at edge t; out_valid=1 from edge t+WA+1.
//   DONE: p_out=acc[WP-1:0] is stable; out_valid=1, in_ready=0.
//     out_valid&out_ready -> IDLE at that edge; in_ready rises the following cycle
//     (no same-cycle accept-and-release).
//   in_valid while busy: ignored, no side effect; operands are not re-sampled.
//   out_ready while not DONE: ignored.
//   Width rules: unsigned a*b never overflows WP bits (max (2^WA-1)(2^WB-1)).
//   A=0 or B=0: still WA RUN cycles, p_out=0 (no early termination).
//   Async reset mid-RUN/DONE: operation is discarded; return to reset values;
//     no out_valid pulse is emitted for the discarded operation.
// CONFIGURATION
//   MULT_SIGNED_EN defined: a_in, b_in and p_out are two's complement. B is
//     sign-extended into the adder. On the final iteration (cnt==WA-1) with
//     A[WA-1]=1, the adder subtracts B instead of adding. Latency unchanged.
//   Not defined: all operands unsigned, add-only datapath, no subtract logic.
// STRUCTURE
//   mult_defs.vh (shared header, `include guarded): FSM state encodings
//     ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; counter width macro
//     MULT_CLOG2 helper.
//   Sub-module mult_add_stage: parametrised (W) combinational add/subtract,
//     inputs x, y, sub; outputs s[W-1:0], co. Replaces chained four_bit_add.
//   Top: FSM + counter + acc shift/update + handshake regs.
// TESTING
//   1 Reset: rst_n=0 mid-RUN -> out_valid=0, busy=0, p_out=0 instantly; in_ready=1 after release.
//   2 Unsigned default: a=7, b=15 -> p_out=105 (7'h69); out_valid at accept+4 edges.
//   3 Backpressure: a=7, b=6, out_ready=0 for 5 cycles -> p_out=42 held, in_ready=0;
//     new in_valid ignored; release -> IDLE, next op result unaffected.
//   4 Zero/edge: a=0, b=15 -> 0; a=7, b=0 -> 0; both with full WA-cycle latency.
//   5 MULT_SIGNED_EN: a=3'b111(-1), b=4'b0110(6) -> p_out=7'b1111010(-6);
//     a=3'b100(-4), b=4'b1000(-8) -> p_out=7'b0100000(32).
//   6 Params WA=8, WB=8: a=255, b=255 -> 65025; back-to-back ops, out_ready tied 1.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encodings and the counter-width helper.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int mult_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mult_add_stage.sv
// Combinational W-bit add/subtract used for one partial-product step.
// When sub=1 the result is x - y; co carries out of the top bit.
module mult_add_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         co
);

  // Single adder; subtraction reuses it via the wider difference.
  always_comb begin
    if (sub) {co, s} = {1'b0, x} - {1'b0, y};
    else     {co, s} = {1'b0, x} + {1'b0, y};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit retired per clock,
// valid/ready on both operand and product sides, one operation in flight.
// Build option: MULT_SIGNED_EN selects two's-complement operands/product
// (B sign-extended, final iteration subtracts when A's MSB is set).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WA = 3,
  parameter int WB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    a_in,
  input  logic [WB-1:0]    b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] p_out,
  output logic             busy
);

  localparam int WP = WA + WB;
  localparam int CW = mult_clog2(WA);
  localparam int AW = WB + 1;

  state_t          state;
  logic [WA-1:0]   a_q;
  logic [WB-1:0]   b_q;
  logic [WP:0]     acc;
  logic [CW-1:0]   cnt;

  logic            last_iter;
  logic            a_bit;
  logic            sub;
  logic [AW-1:0]   win_x;
  logic [AW-1:0]   add_y;
  logic [AW-1:0]   sum;
  logic            co;
  logic [WP:0]     sum_ext;
  logic [WP:0]     low_mask;
  logic [WP:0]     acc_next;

  // Window of the accumulator aligned to the current multiplier bit, and the
  // updated accumulator with the window result written back at that offset.
  always_comb begin
    last_iter = (cnt == CW'(WA - 1));
    a_bit     = a_q[cnt];
    win_x     = AW'(acc >> cnt);
`ifdef MULT_SIGNED_EN
    add_y     = {b_q[WB-1], b_q};
    sub       = last_iter;
    sum_ext   = {{(WP + 1 - AW){sum[AW-1]}}, sum};
`else
    add_y     = {1'b0, b_q};
    sub       = 1'b0;
    sum_ext   = {{(WP - AW){1'b0}}, co, sum};
`endif
    low_mask  = ({{WP{1'b0}}, 1'b1} << cnt) - {{WP{1'b0}}, 1'b1};
    acc_next  = (acc & low_mask) | (sum_ext << cnt);
  end

  mult_add_stage #(.W(AW)) u_add (
    .x   (win_x),
    .y   (add_y),
    .sub (sub),
    .s   (sum),
    .co  (co)
  );

  // Control FSM with registered handshake outputs, operand capture and
  // accumulator update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p_out     <= '0;
      acc       <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a_in;
            b_q      <= b_in;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (a_bit) acc <= acc_next;
          if (last_iter) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // First DONE cycle registers the product; afterwards wait for accept.
          if (!out_valid) begin
            p_out     <= acc[WP-1:0];
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a 3x4 instance driven from a vector
// table plus reset/backpressure sequences, and an 8x8 instance run
// back-to-back with out_ready tied high.
module tb_seq_multiplier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] a_in;
  logic [3:0] b_in;
  logic [6:0] p_out;

  logic        bg_in_valid, bg_in_ready, bg_out_valid, bg_busy;
  logic [7:0]  bg_a, bg_b;
  logic [15:0] bg_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WA(3), .WB(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .busy(busy)
  );

  seq_multiplier #(.WA(8), .WB(8)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(bg_in_valid), .in_ready(bg_in_ready),
    .a_in(bg_a), .b_in(bg_b), .out_valid(bg_out_valid), .out_ready(1'b1),
    .p_out(bg_p), .busy(bg_busy)
  );

  typedef struct {
    logic [2:0] a;
    logic [3:0] b;
    logic [6:0] p;
    string      name;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One full transaction on the small instance, product accepted immediately.
  task automatic run_op(input logic [2:0] a, input logic [3:0] b,
                        input logic [6:0] exp, input string name);
    int lat;
    @(negedge clk);
    chk({name, "_in_ready"}, {31'd0, in_ready}, 1);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = ~a; b_in = ~b;
    chk({name, "_busy"}, {31'd0, busy}, 1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_p"}, {25'd0, p_out}, {25'd0, exp});
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({name, "_released"}, {29'd0, out_valid, busy, ~in_ready}, 0);
  endtask

  // One transaction on the 8x8 instance; out_ready is tied high.
  task automatic run_big(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input string name);
    int lat;
    int w;
    w = 0;
    while (bg_in_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({name, "_ready_wait"}, {31'd0, bg_in_ready}, 1);
    @(negedge clk);
    bg_in_valid = 1'b1; bg_a = a; bg_b = b;
    @(posedge clk); #1;
    bg_in_valid = 1'b0;
    lat = 0;
    while (bg_out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    chk({name, "_latency"}, lat, 9);
    chk({name, "_p"}, {16'd0, bg_p}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  exp_bp;
    logic [15:0] exp_b0, exp_b1;
    int lat;
    logic stray;

`ifdef MULT_SIGNED_EN
    vecs[0] = '{3'd7, 4'd6,  7'h7A, "s_m1x6"};
    vecs[1] = '{3'd4, 4'd8,  7'h20, "s_m4xm8"};
    vecs[2] = '{3'd0, 4'd15, 7'h00, "s_zero_a"};
    vecs[3] = '{3'd7, 4'd0,  7'h00, "s_zero_b"};
    vecs[4] = '{3'd2, 4'd15, 7'h7E, "s_2xm1"};
    vecs[5] = '{3'd3, 4'd7,  7'd21, "s_3x7"};
    vecs[6] = '{3'd5, 4'd9,  7'd21, "s_m3xm7"};
    exp_bp  = 7'h7A;
    exp_b0  = 16'd1;
    exp_b1  = 16'hFF58;
`else
    vecs[0] = '{3'd7, 4'd15, 7'd105, "u_7x15"};
    vecs[1] = '{3'd0, 4'd15, 7'd0,   "u_zero_a"};
    vecs[2] = '{3'd7, 4'd0,  7'd0,   "u_zero_b"};
    vecs[3] = '{3'd5, 4'd9,  7'd45,  "u_5x9"};
    vecs[4] = '{3'd3, 4'd4,  7'd12,  "u_3x4"};
    vecs[5] = '{3'd1, 4'd1,  7'd1,   "u_1x1"};
    vecs[6] = '{3'd6, 4'd11, 7'd66,  "u_6x11"};
    exp_bp  = 7'd42;
    exp_b0  = 16'd65025;
    exp_b1  = 16'd600;
`endif

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    bg_in_valid = 1'b0; bg_a = '0; bg_b = '0;

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_p_out", {25'd0, p_out}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 1);

    // Vector table
    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);

    // Reset asserted mid-RUN
    @(negedge clk); in_valid = 1'b1; a_in = 3'd3; b_in = 4'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrun_busy_before", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 0);
    chk("midrun_rst_out_valid", {31'd0, out_valid}, 0);
    @(negedge clk); rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stray = stray | out_valid;
    end
    chk("midrun_no_stray_valid", {31'd0, stray}, 0);
    chk("midrun_in_ready", {31'd0, in_ready}, 1);

    // Reset asserted while a product is held in DONE
    @(negedge clk); in_valid = 1'b1; a_in = 3'd3; b_in = 4'd7;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("middone_p_before", {25'd0, p_out}, 21);
    #2 rst_n = 1'b0;
    #1;
    chk("middone_rst_p_out", {25'd0, p_out}, 0);
    chk("middone_rst_out_valid", {31'd0, out_valid}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Backpressure with stray in_valid held during RUN/DONE
    @(negedge clk); in_valid = 1'b1; a_in = 3'd7; b_in = 4'd6;
    @(posedge clk); #1; a_in = 3'd1; b_in = 4'd1;
    out_ready = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_latency", lat, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_p_held", {25'd0, p_out}, {25'd0, exp_bp});
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_release_out_valid", {31'd0, out_valid}, 0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 1);
    run_op(3'd2, 4'd3, 7'd6, "after_bp");

    // 8x8 instance, back-to-back
    run_big(8'd255, 8'd255, exp_b0, "big_255x255");
    run_big(8'd200, 8'd3, exp_b1, "big_200x3");
    run_big(8'd0, 8'd99, 16'd0, "big_0x99");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
